// File: rtl/systolic_pe.sv
// Output-stationary MAC processing element: forwards operands, accumulates a tile,
// holds the finished dot product and shifts it out on a per-column drain chain.
module systolic_pe #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ACC_W    = 32,
    parameter int unsigned SIGNED   = 0,
    parameter int unsigned SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] inp_north,
    input  logic              valid_north,
    input  logic [DATA_W-1:0] inp_west,
    input  logic              valid_west,
    input  logic              last_west,
    output logic [DATA_W-1:0] outp_south,
    output logic              valid_south,
    output logic [DATA_W-1:0] outp_east,
    output logic              valid_east,
    output logic              last_east,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid,
    output logic              result_ovf,
    input  logic              drain_en,
    input  logic [ACC_W-1:0]  drain_in,
    input  logic              drain_in_valid,
    output logic [ACC_W-1:0]  drain_out,
    output logic              drain_out_valid
);

    localparam int unsigned PROD_W    = 2 * DATA_W;
    localparam int unsigned SUM_W     = ACC_W + 1;
    localparam int unsigned EXT_W     = SUM_W - PROD_W;
    localparam bit          IS_SIGNED = (SIGNED != 0);
    localparam bit          IS_SAT    = (SATURATE != 0);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FULL,
        S_PASS
    } state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic               r_acc_ovf;

    logic [PROD_W-1:0]  w_opn;
    logic [PROD_W-1:0]  w_opw;
    logic [PROD_W-1:0]  w_prod;
    logic [SUM_W-1:0]   w_prod_x;
    logic [SUM_W-1:0]   w_acc_x;
    logic [SUM_W-1:0]   w_sum;
    logic               w_add_ovf;
    logic [ACC_W-1:0]   w_sat_val;
    logic [ACC_W-1:0]   w_mac;
    logic [ACC_W-1:0]   w_acc_next;
    logic               w_ovf_next;
    logic               w_fire;
    logic               w_tile_end;
    logic               w_unload;
    logic               w_overrun;

    // Operands are extended to the full product width so one multiplier serves both modes.
    assign w_opn    = {{DATA_W{IS_SIGNED & inp_north[DATA_W-1]}}, inp_north};
    assign w_opw    = {{DATA_W{IS_SIGNED & inp_west[DATA_W-1]}}, inp_west};
    assign w_prod   = w_opn * w_opw;
    assign w_prod_x = {{EXT_W{IS_SIGNED & w_prod[PROD_W-1]}}, w_prod};
    assign w_acc_x  = {IS_SIGNED & r_acc[ACC_W-1], r_acc};
    assign w_sum    = w_acc_x + w_prod_x;

    assign w_add_ovf = IS_SIGNED ? (w_sum[ACC_W] ^ w_sum[ACC_W-1]) : w_sum[ACC_W];
    assign w_sat_val = !IS_SIGNED   ? {ACC_W{1'b1}} :
                       w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                      {1'b0, {(ACC_W-1){1'b1}}};
    assign w_mac     = (w_add_ovf && IS_SAT) ? w_sat_val : w_sum[ACC_W-1:0];

    assign w_fire     = valid_north & valid_west;
    assign w_tile_end = valid_west & last_west;
    assign w_acc_next = w_fire ? w_mac : r_acc;
    assign w_ovf_next = r_acc_ovf | (w_fire & w_add_ovf);

    // Capturing over an undrained result that is not leaving this cycle is an overrun.
    assign w_unload  = (r_state == S_FULL) & drain_en;
    assign w_overrun = result_valid & ~w_unload;

    always_ff @(posedge clk) begin
        if (rst) begin
            outp_south      <= '0;
            valid_south     <= 1'b0;
            outp_east       <= '0;
            valid_east      <= 1'b0;
            last_east       <= 1'b0;
            r_acc           <= '0;
            r_acc_ovf       <= 1'b0;
            result          <= '0;
            result_valid    <= 1'b0;
            result_ovf      <= 1'b0;
            drain_out       <= '0;
            drain_out_valid <= 1'b0;
            r_state         <= S_EMPTY;
        end else begin
            outp_south  <= inp_north;
            valid_south <= valid_north;
            outp_east   <= inp_west;
            valid_east  <= valid_west;
            last_east   <= last_west;

            if (w_tile_end) begin
                result       <= w_acc_next;
                result_ovf   <= w_ovf_next | w_overrun;
                result_valid <= 1'b1;
                r_acc        <= '0;
                r_acc_ovf    <= 1'b0;
            end else begin
                r_acc     <= w_acc_next;
                r_acc_ovf <= w_ovf_next;
                if (w_unload) begin
                    result_valid <= 1'b0;
                end
            end

            drain_out_valid <= 1'b0;
            case (r_state)
                S_EMPTY: begin
                    if (drain_en) begin
                        drain_out       <= drain_in;
                        drain_out_valid <= drain_in_valid;
                        r_state         <= S_PASS;
                    end else if (w_tile_end) begin
                        r_state <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (drain_en) begin
                        drain_out       <= result;
                        drain_out_valid <= 1'b1;
                        r_state         <= S_PASS;
                    end
                end
                S_PASS: begin
                    if (drain_en) begin
                        drain_out       <= drain_in;
                        drain_out_valid <= drain_in_valid;
                    end else begin
                        r_state <= (result_valid | w_tile_end) ? S_FULL : S_EMPTY;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_pe.sv
// Bench for systolic_pe: five PEs (three chained unsigned/saturating, one wrapping,
// one signed) checked every cycle against an arithmetic model of tiles and drain.
module tb_systolic_pe;

    localparam int NP = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] inn [NP];
    logic [15:0] inw [NP];
    logic        vn  [NP];
    logic        vw  [NP];
    logic        lw  [NP];
    logic        den [NP];
    logic [31:0] din [NP];
    logic        div [NP];

    logic [15:0] os  [NP];
    logic [15:0] oe  [NP];
    logic        vs  [NP];
    logic        ve  [NP];
    logic        le  [NP];
    logic [31:0] res [NP];
    logic        rv  [NP];
    logic        rov [NP];
    logic [31:0] dout[NP];
    logic        dov [NP];
    logic [31:0] chain_in [NP];
    logic        chain_iv [NP];

    longint      macc [NP];
    logic        movf [NP];
    logic [31:0] mres [NP];
    logic        mrv  [NP];
    logic        mrov [NP];
    logic [31:0] mdo  [NP];
    logic        mdov [NP];
    logic        mpen [NP];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // PE0 -> PE1 -> PE2 form a drain column; PE3 wraps, PE4 is signed.
    for (genvar g = 0; g < NP; g++) begin : g_pe
        if (g == 1 || g == 2) begin : g_chain
            assign chain_in[g] = dout[g-1];
            assign chain_iv[g] = dov[g-1];
        end else begin : g_top
            assign chain_in[g] = din[g];
            assign chain_iv[g] = div[g];
        end
        systolic_pe #(
            .DATA_W  (16),
            .ACC_W   (32),
            .SIGNED  ((g == 4) ? 1 : 0),
            .SATURATE((g == 3) ? 0 : 1)
        ) u_pe (
            .clk            (clk),
            .rst            (rst),
            .inp_north      (inn[g]),
            .valid_north    (vn[g]),
            .inp_west       (inw[g]),
            .valid_west     (vw[g]),
            .last_west      (lw[g]),
            .outp_south     (os[g]),
            .valid_south    (vs[g]),
            .outp_east      (oe[g]),
            .valid_east     (ve[g]),
            .last_east      (le[g]),
            .result         (res[g]),
            .result_valid   (rv[g]),
            .result_ovf     (rov[g]),
            .drain_en       (den[g]),
            .drain_in       (chain_in[g]),
            .drain_in_valid (chain_iv[g]),
            .drain_out      (dout[g]),
            .drain_out_valid(dov[g])
        );
    end

    task automatic chk(input string tag, input int idx, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
        end
    endtask

    // One multiply-accumulate in plain integer arithmetic with the PE's overflow policy.
    task automatic mac_step(input int i);
        longint p;
        longint s;
        if (i == 4) p = longint'($signed(inn[i])) * longint'($signed(inw[i]));
        else        p = longint'(inn[i]) * longint'(inw[i]);
        s = macc[i] + p;
        if (i == 4) begin
            if (s > 64'sd2147483647)       begin s = 64'sd2147483647;  movf[i] = 1'b1; end
            else if (s < -64'sd2147483648) begin s = -64'sd2147483648; movf[i] = 1'b1; end
        end else if (i == 3) begin
            if (s > 64'sd4294967295) begin s = s - 64'sd4294967296; movf[i] = 1'b1; end
        end else begin
            if (s > 64'sd4294967295) begin s = 64'sd4294967295; movf[i] = 1'b1; end
        end
        macc[i] = s;
    endtask

    // Advance one clock, update the model from the inputs that were sampled, compare everything.
    task automatic tick();
        logic [31:0] pdo  [NP];
        logic        pdov [NP];
        logic        unload;
        logic        overrun;
        for (int i = 0; i < NP; i++) begin
            pdo[i]  = mdo[i];
            pdov[i] = mdov[i];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (rst) begin
                macc[i] = 0;  movf[i] = 1'b0; mres[i] = '0; mrv[i] = 1'b0;
                mrov[i] = 1'b0; mdo[i] = '0; mdov[i] = 1'b0; mpen[i] = 1'b0;
            end else begin
                unload  = den[i] && !mpen[i] && mrv[i];
                overrun = mrv[i] && !unload;
                if (vn[i] && vw[i]) mac_step(i);
                if (unload) begin
                    mdo[i] = mres[i];
                    mdov[i] = 1'b1;
                end else if (den[i]) begin
                    if (i == 1 || i == 2) begin
                        mdo[i] = pdo[i-1];
                        mdov[i] = pdov[i-1];
                    end else begin
                        mdo[i] = din[i];
                        mdov[i] = div[i];
                    end
                end else begin
                    mdov[i] = 1'b0;
                end
                if (vw[i] && lw[i]) begin
                    mres[i] = 32'(macc[i]);
                    mrov[i] = movf[i] | overrun;
                    mrv[i]  = 1'b1;
                    macc[i] = 0;
                    movf[i] = 1'b0;
                end else if (unload) begin
                    mrv[i] = 1'b0;
                end
                mpen[i] = den[i];
            end
            chk("south",  i, os[i], rst ? 16'h0 : inn[i]);
            chk("vsouth", i, vs[i], rst ? 1'b0 : vn[i]);
            chk("east",   i, oe[i], rst ? 16'h0 : inw[i]);
            chk("veast",  i, ve[i], rst ? 1'b0 : vw[i]);
            chk("least",  i, le[i], rst ? 1'b0 : lw[i]);
            chk("result", i, res[i], mres[i]);
            chk("rvalid", i, rv[i], mrv[i]);
            chk("rovf",   i, rov[i], mrov[i]);
            chk("dout",   i, dout[i], mdo[i]);
            chk("dvalid", i, dov[i], mdov[i]);
        end
    endtask

    task automatic set_all(input logic [15:0] n, input logic [15:0] w, input logic a, input logic b, input logic l);
        for (int i = 0; i < NP; i++) begin
            inn[i] = n; inw[i] = w; vn[i] = a; vw[i] = b; lw[i] = l;
            den[i] = 1'b0; din[i] = '0; div[i] = 1'b0;
        end
    endtask

    task automatic idle_all();
        set_all(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [15:0] rnd_op();
        case ($urandom_range(0, 3))
            0:       return 16'hFFFF;
            1:       return 16'h8000;
            2:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        idle_all();
        tick();
        tick();
        chk("rst_result", 0, res[0], 64'd0);
        chk("rst_rvalid", 0, rv[0], 64'd0);
        rst = 1'b0;

        // Unsigned MAC: 2*3 + 4*5 + 1*7
        set_all(16'd2, 16'd3, 1'b1, 1'b1, 1'b0); tick();
        chk("fwd_south", 0, os[0], 64'd2);
        set_all(16'd4, 16'd5, 1'b1, 1'b1, 1'b0); tick();
        set_all(16'd1, 16'd7, 1'b1, 1'b1, 1'b1); tick();
        idle_all();
        chk("mac33", 0, res[0], 64'd33);
        chk("mac33_rv", 0, rv[0], 64'd1);
        chk("mac33_ovf", 0, rov[0], 64'd0);
        chk("mac33_sgn", 4, res[4], 64'd33);
        tick();

        // Bubble on beat 2
        do_reset();
        set_all(16'd2, 16'd3, 1'b1, 1'b1, 1'b0); tick();
        set_all(16'd4, 16'd5, 1'b0, 1'b1, 1'b0); tick();
        set_all(16'd1, 16'd7, 1'b1, 1'b1, 1'b1); tick();
        idle_all();
        chk("bubble13", 0, res[0], 64'd13);

        // Tile end without a fire
        do_reset();
        set_all(16'd2, 16'd3, 1'b1, 1'b1, 1'b0); tick();
        set_all(16'd9, 16'd9, 1'b0, 1'b1, 1'b1); tick();
        idle_all();
        chk("nofire6", 0, res[0], 64'd6);

        // Saturation vs wrap
        do_reset();
        set_all(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0); tick();
        set_all(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b1); tick();
        idle_all();
        chk("sat_res", 0, res[0], 64'hFFFF_FFFF);
        chk("sat_ovf", 0, rov[0], 64'd1);
        chk("wrap_res", 3, res[3], 64'hFFFC_0002);
        chk("wrap_ovf", 3, rov[3], 64'd1);

        // Signed (-3)*5 + 1*2
        do_reset();
        set_all(16'hFFFD, 16'd5, 1'b1, 1'b1, 1'b0); tick();
        set_all(16'd1, 16'd2, 1'b1, 1'b1, 1'b1); tick();
        idle_all();
        chk("signed_res", 4, res[4], 64'hFFFF_FFF3);
        chk("signed_ovf", 4, rov[4], 64'd0);

        // Drain column 10/20/30 with a back-to-back capture in the bottom PE
        do_reset();
        inn[0] = 16'd2; inw[0] = 16'd5;
        inn[1] = 16'd4; inw[1] = 16'd5;
        inn[2] = 16'd5; inw[2] = 16'd6;
        for (int i = 0; i < 3; i++) begin vn[i] = 1'b1; vw[i] = 1'b1; lw[i] = 1'b1; end
        tick();
        idle_all();
        for (int i = 0; i < 3; i++) den[i] = 1'b1;
        inn[2] = 16'd7; inw[2] = 16'd1; vn[2] = 1'b1; vw[2] = 1'b1; lw[2] = 1'b1;
        tick();
        chk("drain30", 2, dout[2], 64'd30);
        chk("drain30_v", 2, dov[2], 64'd1);
        chk("b2b_res", 2, res[2], 64'd7);
        chk("b2b_rv", 2, rv[2], 64'd1);
        inn[2] = 16'd0; inw[2] = 16'd0; vn[2] = 1'b0; vw[2] = 1'b0; lw[2] = 1'b0;
        tick();
        chk("drain20", 2, dout[2], 64'd20);
        tick();
        chk("drain10", 2, dout[2], 64'd10);
        chk("drain10_v", 2, dov[2], 64'd1);
        idle_all();
        tick();
        chk("drain_idle_v", 2, dov[2], 64'd0);
        chk("pending_rv", 2, rv[2], 64'd1);
        den[2] = 1'b1;
        tick();
        chk("drain7", 2, dout[2], 64'd7);
        idle_all();
        tick();

        // Reset mid-tile, then a 1x1 tile
        do_reset();
        set_all(16'd3, 16'd3, 1'b1, 1'b1, 1'b0); tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_mid_south", 0, os[0], 64'd0);
        set_all(16'd1, 16'd1, 1'b1, 1'b1, 1'b1); tick();
        idle_all();
        chk("after_rst_tile", 0, res[0], 64'd1);

        // Reset mid-drain, then a 1x1 tile
        set_all(16'd2, 16'd2, 1'b1, 1'b1, 1'b1); tick();
        idle_all();
        for (int i = 0; i < NP; i++) den[i] = 1'b1;
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        idle_all();
        chk("rst_drain_v", 0, dov[0], 64'd0);
        chk("rst_drain_rv", 0, rv[0], 64'd0);
        set_all(16'd1, 16'd1, 1'b1, 1'b1, 1'b1); tick();
        idle_all();
        chk("after_rst_drain", 0, res[0], 64'd1);

        // Randomised traffic with independent tiles, bubbles, drains and rare resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NP; i++) begin
                inn[i] = rnd_op();
                inw[i] = rnd_op();
                vn[i]  = ($urandom_range(0, 3) != 0);
                vw[i]  = ($urandom_range(0, 3) != 0);
                lw[i]  = ($urandom_range(0, 5) == 0);
                den[i] = ($urandom_range(0, 4) == 0);
                din[i] = $urandom;
                div[i] = 1'($urandom_range(0, 1));
            end
            tick();
        end
        rst = 1'b0;
        idle_all();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
